// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Watches NUM_CH synchronous lines for rising/falling edges (per-channel mode),
// queues one event per channel, and presents them one at a time through a
// valid/ready slot chosen round-robin. A second edge on a channel that is
// already queued is dropped and flagged in the sticky overrun vector.
// Optional build macro: EDGE_ARB_OVR_CNT_EN adds an 8-bit saturating
// counter (ovr_cnt) of cycles in which at least one new overrun occurred.

module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   data,
  input  logic [2*NUM_CH-1:0] mode,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic [CH_W-1:0]     ev_ch,
  output logic                ev_type,
  output logic [NUM_CH-1:0]   pending,
  output logic [NUM_CH-1:0]   overrun,
  input  logic                overrun_clr
`ifdef EDGE_ARB_OVR_CNT_EN
  ,
  output logic [7:0]          ovr_cnt
`endif
);

  logic [NUM_CH-1:0] data_q;
  logic [NUM_CH-1:0] pend_type;
  logic [CH_W-1:0]   ptr;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] qual;

  logic              load;
  logic              found;
  logic [CH_W-1:0]   pick;
  logic [NUM_CH-1:0] grant_sel;
  logic [NUM_CH-1:0] grant;

  logic [NUM_CH-1:0] pend_nxt;
  logic [NUM_CH-1:0] type_nxt;
  logic [NUM_CH-1:0] ovr_new;

  // Edge detection against last cycle's sample, filtered by each channel's mode bits.
  always_comb begin
    rise = '0;
    fall = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rise[i] = data[i] & ~data_q[i] & mode[2*i];
      fall[i] = ~data[i] & data_q[i] & mode[2*i+1];
    end
    qual = rise | fall;
  end

  // Round-robin search of the queued events, starting at ptr and wrapping.
  always_comb begin : arb
    int idx;
    idx       = 0;
    found     = 1'b0;
    pick      = '0;
    grant_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && pending[idx]) begin
        found          = 1'b1;
        pick           = idx[CH_W-1:0];
        grant_sel[idx] = 1'b1;
      end
    end
    load  = ~ev_valid | ev_ready;
    grant = load ? grant_sel : '0;
  end

  // Queue update: a channel being moved into the slot this cycle may take a fresh event.
  always_comb begin
    pend_nxt = pending & ~grant;
    type_nxt = pend_type;
    ovr_new  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (qual[i]) begin
        if (pending[i] && !grant[i]) begin
          ovr_new[i] = 1'b1;
        end else begin
          pend_nxt[i] = 1'b1;
          type_nxt[i] = rise[i];
        end
      end
    end
  end

  // Registered state: sample history, queue, overrun flags and the output slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      pending   <= '0;
      pend_type <= '0;
      overrun   <= '0;
      ptr       <= '0;
      ev_valid  <= 1'b0;
      ev_ch     <= '0;
      ev_type   <= 1'b0;
    end else begin
      data_q    <= data;
      pending   <= pend_nxt;
      pend_type <= type_nxt;
      overrun   <= (overrun_clr ? '0 : overrun) | ovr_new;
      if (load) begin
        ev_valid <= found;
        if (found) begin
          ev_ch   <= pick;
          ev_type <= pend_type[pick];
          ptr     <= (pick == CH_W'(NUM_CH - 1)) ? '0 : pick + 1'b1;
        end
      end
    end
  end

`ifdef EDGE_ARB_OVR_CNT_EN
  // Saturating count of cycles with a new overrun; a new overrun beats a clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr_cnt <= 8'd0;
    end else if (|ovr_new) begin
      if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
    end else if (overrun_clr) begin
      ovr_cnt <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter
// Directed scenarios followed by a randomized run, all compared every cycle
// against an event-queue reference model. Honors EDGE_ARB_OVR_CNT_EN.

module tb_edge_event_arbiter;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                clk;
  logic                rst_n;
  logic [NUM_CH-1:0]   data;
  logic [2*NUM_CH-1:0] mode;
  logic                ev_valid;
  logic                ev_ready;
  logic [CH_W-1:0]     ev_ch;
  logic                ev_type;
  logic [NUM_CH-1:0]   pending;
  logic [NUM_CH-1:0]   overrun;
  logic                overrun_clr;
`ifdef EDGE_ARB_OVR_CNT_EN
  logic [7:0]          ovr_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_dq   [NUM_CH];
  bit m_pend [NUM_CH];
  bit m_ptype[NUM_CH];
  bit m_ovr  [NUM_CH];
  bit m_valid;
  int m_ch;
  bit m_type;
  int m_ptr;
  int m_cnt;

  edge_event_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .mode       (mode),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_ch      (ev_ch),
    .ev_type    (ev_type),
    .pending    (pending),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`ifdef EDGE_ARB_OVR_CNT_EN
    ,
    .ovr_cnt    (ovr_cnt)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] packBits(bit v[NUM_CH]);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic expectEq(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model one rising clock edge from the rules: arbitration over the queue,
  // then edge capture with drop-and-flag when the channel is still queued.
  task automatic modelEdge();
    int  chosen;
    bit  accept;
    bit  anyNew;
    bit  oldPend[NUM_CH];
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_dq[i] = 0; m_pend[i] = 0; m_ptype[i] = 0; m_ovr[i] = 0;
      end
      m_valid = 0; m_ch = 0; m_type = 0; m_ptr = 0; m_cnt = 0;
      return;
    end
    accept = !m_valid || ev_ready;
    chosen = -1;
    if (accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_ptr + k) % NUM_CH;
        if (chosen < 0 && m_pend[c]) chosen = c;
      end
    end
    if (overrun_clr) for (int i = 0; i < NUM_CH; i++) m_ovr[i] = 0;
    oldPend = m_pend;
    if (accept) begin
      if (chosen >= 0) begin
        m_valid        = 1;
        m_ch           = chosen;
        m_type         = m_ptype[chosen];
        m_pend[chosen] = 0;
        m_ptr          = (chosen + 1) % NUM_CH;
      end else begin
        m_valid = 0;
      end
    end
    anyNew = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      bit isRise, isFall;
      isRise = data[i] && !m_dq[i];
      isFall = !data[i] && m_dq[i];
      if ((isRise && mode[2*i]) || (isFall && mode[2*i+1])) begin
        if (oldPend[i] && i != chosen) begin
          m_ovr[i] = 1;
          anyNew   = 1;
        end else begin
          m_pend[i]  = 1;
          m_ptype[i] = isRise;
        end
      end
      m_dq[i] = data[i];
    end
    if (anyNew) begin
      if (m_cnt < 255) m_cnt++;
    end else if (overrun_clr) begin
      m_cnt = 0;
    end
  endtask

  task automatic checkOutput();
    expectEq("ev_valid", 16'(ev_valid), 16'(m_valid));
    expectEq("pending", 16'(pending), packBits(m_pend));
    expectEq("overrun", 16'(overrun), packBits(m_ovr));
    if (m_valid) begin
      expectEq("ev_ch", 16'(ev_ch), 16'(m_ch));
      expectEq("ev_type", 16'(ev_type), 16'(m_type));
    end
`ifdef EDGE_ARB_OVR_CNT_EN
    expectEq("ovr_cnt", 16'(ovr_cnt), 16'(m_cnt));
`endif
  endtask

  // Drive one cycle of inputs (away from the edge), advance the model on the
  // edge, then compare at the following falling edge.
  task automatic applyStimulus(logic rn, logic [NUM_CH-1:0] d, logic [2*NUM_CH-1:0] md,
                               logic rdy, logic clr);
    rst_n       = rn;
    data        = d;
    mode        = md;
    ev_ready    = rdy;
    overrun_clr = clr;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    rst_n = 1'b0; data = '0; mode = '0; ev_ready = 1'b0; overrun_clr = 1'b0;

    // Reset state
    applyStimulus(0, 4'b0000, 8'h00, 0, 0);
    applyStimulus(0, 4'b0000, 8'h00, 0, 0);
    expectEq("rst_valid", 16'(ev_valid), 16'd0);
    expectEq("rst_pending", 16'(pending), 16'd0);
    expectEq("rst_overrun", 16'(overrun), 16'd0);
    expectEq("rst_ev_ch", 16'(ev_ch), 16'd0);

    // Single rise on ch2
    $display("[TB] single rise");
    applyStimulus(1, 4'b0000, 8'h55, 1, 0);
    applyStimulus(1, 4'b0100, 8'h55, 1, 0);
    expectEq("rise_pending", 16'(pending), 16'h4);
    expectEq("rise_valid_early", 16'(ev_valid), 16'd0);
    applyStimulus(1, 4'b0100, 8'h55, 1, 0);
    expectEq("rise_valid", 16'(ev_valid), 16'd1);
    expectEq("rise_ch", 16'(ev_ch), 16'd2);
    expectEq("rise_type", 16'(ev_type), 16'd1);
    applyStimulus(1, 4'b0000, 8'h55, 1, 0);
    expectEq("rise_one_cycle", 16'(ev_valid), 16'd0);

    // Round-robin 0,1,3 from a fresh pointer
    $display("[TB] round robin");
    applyStimulus(0, 4'b0000, 8'h55, 1, 0);
    applyStimulus(1, 4'b1011, 8'h55, 1, 0);
    applyStimulus(1, 4'b1011, 8'h55, 1, 0);
    expectEq("rr_first", 16'(ev_ch), 16'd0);
    applyStimulus(1, 4'b1011, 8'h55, 1, 0);
    expectEq("rr_second", 16'(ev_ch), 16'd1);
    applyStimulus(1, 4'b1011, 8'h55, 1, 0);
    expectEq("rr_third", 16'(ev_ch), 16'd3);
    expectEq("rr_third_valid", 16'(ev_valid), 16'd1);
    applyStimulus(1, 4'b0000, 8'h55, 1, 0);
    expectEq("rr_drained", 16'(ev_valid), 16'd0);

    // Backpressure and overrun on ch1 (slot occupied by ch0)
    $display("[TB] backpressure");
    applyStimulus(0, 4'b0000, 8'hFF, 0, 0);
    applyStimulus(1, 4'b0001, 8'hFF, 0, 0);
    applyStimulus(1, 4'b0011, 8'hFF, 0, 0);
    applyStimulus(1, 4'b0001, 8'hFF, 0, 0);
    expectEq("bp_overrun", 16'(overrun), 16'h2);
    expectEq("bp_hold_ch", 16'(ev_ch), 16'd0);
    applyStimulus(1, 4'b0001, 8'hFF, 0, 0);
    expectEq("bp_hold_valid", 16'(ev_valid), 16'd1);
    applyStimulus(1, 4'b0001, 8'hFF, 1, 0);
    expectEq("bp_ch1", 16'(ev_ch), 16'd1);
    expectEq("bp_type_rise", 16'(ev_type), 16'd1);
    applyStimulus(1, 4'b0001, 8'hFF, 1, 0);

    // Mode filter: ch0 falling-only, ch1 off
    $display("[TB] mode filter");
    applyStimulus(0, 4'b0000, 8'h02, 1, 0);
    applyStimulus(1, 4'b0001, 8'h02, 1, 0);
    expectEq("mf_no_rise", 16'(pending), 16'h0);
    applyStimulus(1, 4'b0000, 8'h02, 1, 0);
    applyStimulus(1, 4'b0000, 8'h02, 1, 0);
    expectEq("mf_fall_ch", 16'(ev_ch), 16'd0);
    expectEq("mf_fall_type", 16'(ev_type), 16'd0);
    applyStimulus(1, 4'b0010, 8'h02, 1, 0);
    applyStimulus(1, 4'b0000, 8'h02, 1, 0);
    applyStimulus(1, 4'b0000, 8'h02, 1, 0);
    expectEq("mf_off_valid", 16'(ev_valid), 16'd0);

    // Set wins over clear on ch3
    $display("[TB] set wins");
    applyStimulus(0, 4'b0000, 8'hFF, 0, 0);
    applyStimulus(1, 4'b0001, 8'hFF, 0, 0);
    applyStimulus(1, 4'b1101, 8'hFF, 0, 0);
    applyStimulus(1, 4'b1001, 8'hFF, 0, 0);
    expectEq("sw_before", 16'(overrun), 16'h4);
    applyStimulus(1, 4'b0001, 8'hFF, 0, 1);
    expectEq("sw_after", 16'(overrun), 16'h8);
    applyStimulus(1, 4'b0011, 8'hFF, 0, 0);
    expectEq("mid_pending", 16'(pending), 16'hE);

    // Reset with slot full and three queued events
    $display("[TB] reset mid-operation");
    applyStimulus(0, 4'b0000, 8'hFF, 0, 0);
    expectEq("mr_valid", 16'(ev_valid), 16'd0);
    expectEq("mr_pending", 16'(pending), 16'd0);
    expectEq("mr_overrun", 16'(overrun), 16'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0000, 8'hFF, 1, 0);
    expectEq("mr_quiet", 16'(ev_valid), 16'd0);

    // Randomized traffic
    $display("[TB] random run");
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    NUM_CH'($urandom),
                    (2*NUM_CH)'($urandom),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
